// File: rtl/seg_bcd_display_pkg.sv
// Shared types and constants for the byte-to-two-digit seven-segment display block.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package seg_bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift.
  function automatic logic [11:0] dabbleAdjust(input logic [11:0] bcd);
    logic [11:0] adj;
    adj = bcd;
    for (int n = 0; n < 3; n++) begin
      if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/seg_bcd_display_seg7_encode.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Anything that is not a decimal digit comes out blank.
module seg7_encode
  import seg_bcd_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_bcd_display.sv
// Converts an accepted byte to BCD with an 8-step double-dabble, then shows tens/ones
// on two seven-segment digits, or dashes plus an overflow LED when the value exceeds 99.
module seg_bcd_display
  import seg_bcd_display_pkg::*;
#(
  parameter bit BLANK_LEADING_ZERO = 1'b0
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       ready,
  output logic [6:0] seg_ten,
  output logic [6:0] seg_one,
  output logic       led
);

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_count;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic        r_ready;
  logic [6:0]  r_segTen;
  logic [6:0]  r_segOne;
  logic        r_led;

  logic        w_load;
  logic        w_step;
  logic        w_update;
  logic [11:0] w_adj;
  logic [3:0]  w_tenDigit;
  logic [6:0]  w_tenSeg;
  logic [6:0]  w_oneSeg;

  always_ff @(posedge clk50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (value_valid) w_nextState = CONV;
      CONV:    if (r_count == 3'd7) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_load   = (r_state == IDLE) && value_valid;
    w_step   = (r_state == CONV);
    w_update = (r_state == DONE);
  end

  assign w_adj = dabbleAdjust(r_bcd);

  // A tens digit of 0 is steered to a non-decimal code so the encoder blanks it.
  assign w_tenDigit = (BLANK_LEADING_ZERO && (r_bcd[7:4] == 4'd0)) ? 4'hF : r_bcd[7:4];

  seg7_encode u_encTen (
    .i_digit (w_tenDigit),
    .o_seg   (w_tenSeg)
  );

  seg7_encode u_encOne (
    .i_digit (r_bcd[3:0]),
    .o_seg   (w_oneSeg)
  );

  always_ff @(posedge clk50) begin
    if (reset) begin
      r_count  <= 3'd0;
      r_bin    <= 8'd0;
      r_bcd    <= 12'd0;
      r_ready  <= 1'b1;
      r_segTen <= SEG_BLANK;
      r_segOne <= SEG_BLANK;
      r_led    <= 1'b0;
    end else begin
      r_ready <= (w_nextState == IDLE);
      if (w_load) begin
        r_bin   <= value_in;
        r_bcd   <= 12'd0;
        r_count <= 3'd0;
      end else if (w_step) begin
        r_bcd   <= {w_adj[10:0], r_bin[7]};
        r_bin   <= {r_bin[6:0], 1'b0};
        r_count <= r_count + 3'd1;
      end
      if (w_update) begin
        if (r_bcd[11:8] != 4'd0) begin
          r_segTen <= SEG_DASH;
          r_segOne <= SEG_DASH;
          r_led    <= 1'b1;
        end else begin
          r_segTen <= w_tenSeg;
          r_segOne <= w_oneSeg;
          r_led    <= 1'b0;
        end
      end
    end
  end

  assign ready   = r_ready;
  assign seg_ten = r_segTen;
  assign seg_one = r_segOne;
  assign led     = r_led;

endmodule
